// File: rtl/hamming_seq_ctrl.sv
// Sequences a shared Hamming(7,4) encoder over the eight nibbles of a 32-bit word and packs the codes.
// Optional macro HSEQ_IRQ_EN adds the registered irq_o output.
`timescale 1ns/1ps
module hamming_seq_ctrl #(
    parameter int ENC_LAT = 0,
    parameter int CODE_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic [1:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic [3:0]        enc_nib_o,
    output logic              enc_valid_o,
    input  logic [CODE_W-1:0] enc_code_i,
    output logic              busy_o,
    output logic              done_o
`ifdef HSEQ_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam int         RES_W    = 8 * CODE_W;
    localparam logic [1:0] LAT_INIT = 2'(ENC_LAT);

    if (CODE_W != 7) begin : g_bad_code_w
        $error("hamming_seq_ctrl: CODE_W must be 7");
    end
    if (ENC_LAT < 0 || ENC_LAT > 3) begin : g_bad_enc_lat
        $error("hamming_seq_ctrl: ENC_LAT must be 0..3");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, DONE} state_t;

    state_t           state, state_n;
    logic [31:0]      word;
    logic [RES_W-1:0] acc, result;
    logic [2:0]       idx;
    logic [1:0]       lat_cnt;
    logic             done_q, ovr_q, irq_en_q;
    logic             data_wr, stat_wr, status_clr, accept, ovr_evt, capture, last_nib;

    assign data_wr    = wr_i && (addr_i == 2'd0);
    assign stat_wr    = wr_i && (addr_i == 2'd1);
    assign status_clr = stat_wr && wdata_i[0];
    assign accept     = data_wr && (state == IDLE);
    // The DONE cycle still belongs to the sequence, so a write there is an overrun.
    assign ovr_evt    = data_wr && (state != IDLE);
    assign last_nib   = (idx == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        capture     = 1'b0;
        busy_o      = 1'b0;
        enc_valid_o = 1'b0;
        enc_nib_o   = 4'h0;
        case (state)
            IDLE: if (accept) state_n = DRIVE;
            DRIVE: begin
                busy_o      = 1'b1;
                enc_valid_o = 1'b1;
                enc_nib_o   = word[idx*4 +: 4];
                if (ENC_LAT == 0) begin
                    capture = 1'b1;
                    state_n = last_nib ? DONE : DRIVE;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                busy_o      = 1'b1;
                enc_valid_o = 1'b1;
                enc_nib_o   = word[idx*4 +: 4];
                if (lat_cnt == 2'd1) begin
                    capture = 1'b1;
                    state_n = last_nib ? DONE : DRIVE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            acc      <= '0;
            result   <= '0;
            idx      <= '0;
            lat_cnt  <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            if (accept) begin
                word <= wdata_i;
                idx  <= '0;
            end
            if (state == DRIVE)     lat_cnt <= LAT_INIT;
            else if (state == WAIT) lat_cnt <= lat_cnt - 2'd1;
            if (capture) begin
                acc[idx*CODE_W +: CODE_W] <= enc_code_i;
                idx                       <= idx + 3'd1;
            end
            if (state == DONE) result <= acc;
            // Set terms are OR-ed in last so a new event beats a same-cycle clear.
            done_q <= (done_q & ~status_clr & ~accept) | (capture & last_nib);
            ovr_q  <= (ovr_q & ~status_clr) | ovr_evt;
            if (stat_wr && wdata_i[2]) irq_en_q <= 1'b1;
        end
    end

    assign done_o = done_q;

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            2'd0: rdata_o = word;
            2'd1: rdata_o = {28'h0, irq_en_q, ovr_q, done_q, busy_o};
            2'd2: rdata_o = result[31:0];
            2'd3: rdata_o = {8'h00, result[RES_W-1:32]};
            default: rdata_o = '0;
        endcase
    end

`ifdef HSEQ_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_o <= 1'b0;
        else     irq_o <= irq_en_q & (done_q | ovr_q);
    end
`endif

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Randomized self-checking bench: two controllers (ENC_LAT 0 and 2) against a word-level reference model.
`timescale 1ns/1ps
module tb_hamming_seq_ctrl;

    localparam int LAT_A = 0;
    localparam int LAT_B = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr    [2];
    logic [1:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  nib   [2];
    logic        valid [2];
    logic [6:0]  code  [2];
    logic        busy  [2];
    logic        done  [2];
`ifdef HSEQ_IRQ_EN
    logic        irq   [2];
    logic        irq_at_done, irq_after_done;
`endif

    bit          ham_mode;
    int          n_tests, n_fail;

    // Reference model state per instance
    logic [31:0] m_word [2];
    logic [55:0] m_res  [2];
    bit          m_done [2], m_ovr [2], m_irq_en [2];

    always #5 clk = ~clk;

    function automatic logic [6:0] enc_ref(input logic [3:0] n);
        if (!ham_mode) return {3'b000, n};
        return {n[3], n[2], n[1], n[1]^n[2]^n[3], n[0], n[0]^n[2]^n[3], n[0]^n[1]^n[3]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign code[g] = ham_mode
            ? {nib[g][3], nib[g][2], nib[g][1], nib[g][1]^nib[g][2]^nib[g][3],
               nib[g][0], nib[g][0]^nib[g][2]^nib[g][3], nib[g][0]^nib[g][1]^nib[g][3]}
            : {3'b000, nib[g]};
        hamming_seq_ctrl #(.ENC_LAT(g == 0 ? LAT_A : LAT_B), .CODE_W(7)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .wr_i        (wr[g]),
            .addr_i      (addr[g]),
            .wdata_i     (wdata[g]),
            .rdata_o     (rdata[g]),
            .enc_nib_o   (nib[g]),
            .enc_valid_o (valid[g]),
            .enc_code_i  (code[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g])
`ifdef HSEQ_IRQ_EN
            ,
            .irq_o       (irq[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    // Packs the eight codes, nibble i landing at bit 7*i.
    function automatic logic [55:0] model_result(input logic [31:0] w);
        logic [55:0] r = '0;
        for (int i = 0; i < 8; i++)
            r = r | (56'(enc_ref(w[4*i +: 4])) << (7 * i));
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_word[k] = '0; m_res[k] = '0;
            m_done[k] = 0;  m_ovr[k] = 0; m_irq_en[k] = 0;
        end
    endtask

    task automatic drive(input int k, input logic w, input logic [1:0] a, input logic [31:0] d);
        wr[k] = w; addr[k] = a; wdata[k] = d;
    endtask

    task automatic write_reg(input int k, input logic [1:0] a, input logic [31:0] d);
        drive(k, 1'b1, a, d);
        @(negedge clk);
        drive(k, 1'b0, a, 32'h0);
        if (a == 2'd1) begin
            if (d[0]) begin m_done[k] = 0; m_ovr[k] = 0; end
            if (d[2]) m_irq_en[k] = 1;
        end
    endtask

    task automatic read_check(input int k, input logic [1:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        addr[k] = a;
        #1;
        check(tag, rdata[k], exp);
    endtask

    task automatic check_regs(input int k);
        read_check(k, 2'd0, m_word[k], "rd_data");
        read_check(k, 2'd1, {28'h0, m_irq_en[k], m_ovr[k], m_done[k], 1'b0}, "rd_status");
        read_check(k, 2'd2, m_res[k][31:0], "rd_res_lo");
        read_check(k, 2'd3, {8'h00, m_res[k][55:32]}, "rd_res_hi");
    endtask

    // Runs one sequence; a second DATA write is injected at busy-cycle late_at (-1: none,
    // 8*(lat+1): the DONE cycle). Between writes the bench watches RESULT_LO.
    task automatic run_seq(input int k, input logic [31:0] w, input int late_at);
        int lat  = lat_of(k);
        int blen = 8 * (lat + 1);
        int cyc  = 0;
        write_reg(k, 2'd0, w);
        m_word[k] = w;
        m_done[k] = 0;
        while (busy[k] && cyc < 200) begin
            check("enc_valid", valid[k], 1'b1);
            check("enc_nib", nib[k], w[4*(cyc/(lat+1)) +: 4]);
            if (cyc > 0 && cyc - 1 != late_at)
                check("res_while_busy", rdata[k], m_res[k][31:0]);
            drive(k, cyc == late_at, (cyc == late_at) ? 2'd0 : 2'd2, 32'hFFFF_FFFF);
            cyc++;
            @(negedge clk);
        end
        check("busy_len", cyc, blen);
        check("done_rise", done[k], 1'b1);
        check("done_cycle_valid", valid[k], 1'b0);
`ifdef HSEQ_IRQ_EN
        irq_at_done = irq[k];
`endif
        drive(k, cyc == late_at, 2'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(k, 1'b0, 2'd0, 32'h0);
`ifdef HSEQ_IRQ_EN
        irq_after_done = irq[k];
`endif
        if (late_at >= 0 && late_at <= blen) m_ovr[k] = 1;
        m_done[k] = 1;
        m_res[k]  = model_result(w);
        check("idle_busy", busy[k], 1'b0);
        check("idle_nib", nib[k], 4'h0);
        check_regs(k);
    endtask

    task automatic reset_mid(input int k);
        write_reg(k, 2'd0, 32'h1234_5678);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy[k], 1'b0);
        check("rst_done", done[k], 1'b0);
        check("rst_valid", valid[k], 1'b0);
        check("rst_nib", nib[k], 4'h0);
`ifdef HSEQ_IRQ_EN
        check("rst_irq", irq[k], 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_regs(k);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        ham_mode = 0;
        rst      = 1'b1;
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 2'd0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 2; k++) begin
            check("reset_busy", busy[k], 1'b0);
            check("reset_done", done[k], 1'b0);
            check("reset_valid", valid[k], 1'b0);
            check("reset_nib", nib[k], 4'h0);
            for (int a = 0; a < 4; a++) read_check(k, 2'(a), 32'h0, "reset_rdata");
        end

        // Directed word with the transparent stub encoder
        for (int k = 0; k < 2; k++) begin
            run_seq(k, 32'h8765_4321, -1);
            read_check(k, 2'd2, 32'h5080_C101, "dir_res_lo");
            read_check(k, 2'd3, 32'h0010_1C30, "dir_res_hi");
        end

        // Overrun three cycles in, then in the DONE cycle itself
        for (int k = 0; k < 2; k++) begin
            run_seq(k, 32'h8765_4321, 2);
            read_check(k, 2'd1, 32'h6, "ovr_status");
            read_check(k, 2'd2, 32'h5080_C101, "ovr_res_lo");
            write_reg(k, 2'd1, 32'h1);
            read_check(k, 2'd1, 32'h0, "ovr_cleared");
            run_seq(k, $urandom, 8 * (lat_of(k) + 1));
            read_check(k, 2'd1, 32'h6, "ovr_done_cycle");
            write_reg(k, 2'd1, 32'h1);
        end

        // Random words through a real Hamming encoder
        ham_mode = 1;
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 2; k++) begin
                int blen = 8 * (lat_of(k) + 1);
                int late = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, blen)) : -1;
                if ($urandom_range(0, 1) == 1) write_reg(k, 2'd1, 32'h1);
                run_seq(k, $urandom, late);
            end
        end

        for (int k = 0; k < 2; k++) begin
            write_reg(k, 2'd1, 32'h4);
            check_regs(k);
        end

        reset_mid(0);
        reset_mid(1);
        for (int k = 0; k < 2; k++) run_seq(k, $urandom, -1);

`ifdef HSEQ_IRQ_EN
        write_reg(0, 2'd1, 32'h1);
        write_reg(0, 2'd1, 32'h4);
        run_seq(0, 32'h0000_0001, -1);
        check("irq_low_in_done", irq_at_done, 1'b0);
        check("irq_after_done", irq_after_done, 1'b1);
        write_reg(0, 2'd1, 32'h1);
        @(negedge clk);
        check("irq_cleared", irq[0], 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
